// File: rtl/st506_seek_engine.sv
// st506_seek_engine: ST-506/ESDI seek and recalibrate step sequencer with settle, timeout and fault handling
module st506_seek_engine #(
   parameter int CYL_W       = 11,
   parameter int CNT_W       = 24,
   parameter int MAX_CYL     = 1023,
   parameter int SETUP_CYC   = 300,
   parameter int HOLD_CYC    = 300,
   parameter int SC_BLANK    = 600,
   parameter int RECAL_LIMIT = 2047
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_recal,
   input  logic [CYL_W-1:0] cmd_cyl,
   input  logic             buffered_mode,
   input  logic [15:0]      step_width,
   input  logic [CNT_W-1:0] step_period,
   input  logic [CNT_W-1:0] settle_timeout,
   input  logic             seek_complete,
   input  logic             at_track00,
   input  logic             drive_fault,
   output logic             step_pulse,
   output logic             step_direction,
   output logic [CYL_W-1:0] cur_cyl,
   output logic             cal_valid,
   output logic             busy,
   output logic             done,
   output logic [2:0]       err_code
);
   typedef enum logic [2:0] {IDLE, CALC, SETUP, PULSE, HOLD, GAP, SETTLE, DONE} state_t;
   state_t state_q, state_d;
   logic [CYL_W-1:0] cur_q, cur_d, tgt_q, tgt_d, left_q, left_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, period_q, period_d, tmo_q, tmo_d;
   logic [15:0] width_q, width_d;
   logic recal_q, recal_d, buf_q, buf_d, dir_q, dir_d, cal_q, cal_d;
   logic [2:0] err_q, err_d;
   logic accept;
   // state and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cur_q    <= '0;
         tgt_q    <= '0;
         left_q   <= '0;
         cnt_q    <= '0;
         period_q <= '0;
         tmo_q    <= '0;
         width_q  <= '0;
         recal_q  <= 1'b0;
         buf_q    <= 1'b0;
         dir_q    <= 1'b0;
         cal_q    <= 1'b0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         tgt_q    <= tgt_d;
         left_q   <= left_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         tmo_q    <= tmo_d;
         width_q  <= width_d;
         recal_q  <= recal_d;
         buf_q    <= buf_d;
         dir_q    <= dir_d;
         cal_q    <= cal_d;
         err_q    <= err_d;
      end
   end
   // next-state logic; the phase counter restarts on every state change
   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      tgt_d    = tgt_q;
      left_d   = left_q;
      period_d = period_q;
      tmo_d    = tmo_q;
      width_d  = width_q;
      recal_d  = recal_q;
      buf_d    = buf_q;
      dir_d    = dir_q;
      cal_d    = cal_q;
      err_d    = err_q;
      cnt_inc  = cnt_q + CNT_W'(1);
      accept   = cmd_valid && (state_q == IDLE || state_q == DONE);
      if (drive_fault && state_q != IDLE && state_q != DONE) begin
         state_d = DONE;
         err_d   = 3'd3;
         cal_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               state_d = accept ? CALC : IDLE;
               if (accept) begin
                  recal_d  = cmd_recal;
                  tgt_d    = cmd_cyl;
                  buf_d    = buffered_mode;
                  width_d  = step_width;
                  period_d = step_period;
                  tmo_d    = settle_timeout;
                  err_d    = 3'd0;
               end
            end
            CALC: begin
               if (recal_q) begin
                  dir_d   = 1'b0;
                  left_d  = CYL_W'(RECAL_LIMIT);
                  state_d = at_track00 ? SETTLE : SETUP;
               end else if (!cal_q) begin
                  state_d = DONE;
                  err_d   = 3'd5;
               end else if (int'(tgt_q) > MAX_CYL) begin
                  state_d = DONE;
                  err_d   = 3'd4;
               end else if (tgt_q == cur_q) begin
                  state_d = DONE;
               end else begin
                  dir_d   = tgt_q > cur_q;
                  left_d  = (tgt_q > cur_q) ? tgt_q - cur_q : cur_q - tgt_q;
                  state_d = SETUP;
               end
            end
            SETUP: state_d = (cnt_inc >= CNT_W'(SETUP_CYC)) ? PULSE : SETUP;
            PULSE: begin
               if (cnt_inc >= CNT_W'(width_q)) begin
                  state_d = HOLD;
                  left_d  = left_q - CYL_W'(1);
                  cur_d   = recal_q ? cur_q : dir_q ? cur_q + CYL_W'(1) : cur_q - CYL_W'(1);
               end
            end
            HOLD: begin
               if (cnt_inc >= CNT_W'(HOLD_CYC))
                  state_d = (!recal_q && buf_q && left_q != '0) ? GAP : SETTLE;
            end
            GAP: state_d = (cnt_inc >= period_q) ? SETUP : GAP;
            SETTLE: begin
               if (seek_complete && cnt_q >= CNT_W'(SC_BLANK)) begin
                  if (recal_q && at_track00) begin
                     state_d = DONE;
                     cur_d   = '0;
                     cal_d   = 1'b1;
                  end else if (recal_q && left_q == '0) begin
                     state_d = DONE;
                     err_d   = 3'd2;
                     cal_d   = 1'b0;
                  end else begin
                     state_d = (recal_q || left_q != '0) ? SETUP : DONE;
                  end
               end else if (cnt_inc >= tmo_q) begin
                  state_d = DONE;
                  err_d   = 3'd1;
                  cal_d   = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      cnt_d = (state_d != state_q) ? '0 : cnt_inc;
   end
   // outputs decoded from the registered state
   always_comb begin
      busy           = state_q != IDLE && state_q != DONE;
      cmd_ready      = ~busy;
      done           = state_q == DONE;
      step_pulse     = state_q == PULSE;
      step_direction = dir_q;
      cur_cyl        = cur_q;
      cal_valid      = cal_q;
      err_code       = err_q;
   end
endmodule

// File: tb/tb_st506_seek_engine.sv
// tb_st506_seek_engine: directed checks of seek, recalibrate, timeout, fault and reset behaviour
module tb_st506_seek_engine;
   localparam int CYL_W = 6, CNT_W = 16, MAX_CYL = 20, SETUP_CYC = 3, HOLD_CYC = 2, SC_BLANK = 4, RECAL_LIMIT = 6;
   logic clk = 0, reset, cmd_valid, cmd_ready, cmd_recal, buffered_mode, seek_complete, at_track00, drive_fault;
   logic [CYL_W-1:0] cmd_cyl, cur_cyl;
   logic [15:0] step_width;
   logic [CNT_W-1:0] step_period, settle_timeout;
   logic step_pulse, step_direction, cal_valid, busy, done;
   logic [2:0] err_code;
   int tests = 0, failed = 0;
   int cyc = 0, npulse = 0, base = 0, n = 0;
   int rise_at[256], w_at[256];
   logic dir_at[256];
   logic prev_p = 0, ok;
   logic t00_force = 0;
   int t00_after = 0, t00_base = 0;

   st506_seek_engine #(
      .CYL_W(CYL_W), .CNT_W(CNT_W), .MAX_CYL(MAX_CYL), .SETUP_CYC(SETUP_CYC),
      .HOLD_CYC(HOLD_CYC), .SC_BLANK(SC_BLANK), .RECAL_LIMIT(RECAL_LIMIT)
   ) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_recal(cmd_recal),
      .cmd_cyl(cmd_cyl), .buffered_mode(buffered_mode), .step_width(step_width), .step_period(step_period),
      .settle_timeout(settle_timeout), .seek_complete(seek_complete), .at_track00(at_track00),
      .drive_fault(drive_fault), .step_pulse(step_pulse), .step_direction(step_direction), .cur_cyl(cur_cyl),
      .cal_valid(cal_valid), .busy(busy), .done(done), .err_code(err_code)
   );

   always #5 clk = ~clk;

   // drive model: track00 appears once the given number of steps has been issued
   assign at_track00 = t00_force || (t00_after != 0 && npulse - t00_base >= t00_after);

   // pulse monitor: records rise cycle, width and direction of every step pulse
   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (step_pulse && !prev_p) begin
         rise_at[npulse] = cyc;
         dir_at[npulse] = step_direction;
         w_at[npulse] = 0;
         npulse++;
      end
      if (step_pulse) w_at[npulse-1]++;
      prev_p = step_pulse;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic r, input int cyl, input logic b, input int w, input int per, input int tmo);
      cmd_recal = r;
      cmd_cyl = CYL_W'(cyl);
      buffered_mode = b;
      step_width = 16'(w);
      step_period = CNT_W'(per);
      settle_timeout = CNT_W'(tmo);
      cmd_valid = 1;
      @(negedge clk);
      cmd_valid = 0;
   endtask

   task automatic wait_done(input int lim, input string tag);
      int k = 0;
      while (done !== 1'b1 && k < lim) begin
         @(negedge clk);
         k++;
      end
      chk({tag, " done"}, done, 1);
   endtask

   task automatic recal_force();
      t00_force = 1;
      issue(1, 0, 0, 1, 1, 1000);
      wait_done(100, "recal00");
      t00_force = 0;
   endtask

   initial begin
      reset = 1; cmd_valid = 0; cmd_recal = 0; cmd_cyl = 0; buffered_mode = 0; step_width = 1;
      step_period = 1; settle_timeout = 100; seek_complete = 1; drive_fault = 0;
      repeat (3) @(negedge clk);
      chk("rst step_pulse", step_pulse, 0);
      chk("rst step_dir", step_direction, 0);
      chk("rst cur_cyl", cur_cyl, 0);
      chk("rst cal_valid", cal_valid, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst err", err_code, 0);
      chk("rst ready", cmd_ready, 1);
      reset = 0;
      @(negedge clk);
      // seek before calibration
      base = npulse;
      issue(0, 4, 0, 2, 1, 1000);
      chk("nocal busy", busy, 1);
      chk("nocal early done", done, 0);
      @(negedge clk);
      chk("nocal done", done, 1);
      chk("nocal err", err_code, 5);
      chk("nocal busy at done", busy, 0);
      @(negedge clk);
      chk("nocal err held", err_code, 5);
      chk("nocal pulses", npulse - base, 0);
      // recalibrate, track00 after the 5th step
      base = npulse; t00_base = npulse; t00_after = 5;
      issue(1, 0, 0, 2, 1, 1000);
      wait_done(400, "recal");
      chk("recal pulses", npulse - base, 5);
      chk("recal err", err_code, 0);
      chk("recal cal", cal_valid, 1);
      chk("recal cur", cur_cyl, 0);
      ok = 1;
      for (int i = 0; i < 5; i++) if (dir_at[base+i] !== 1'b0 || w_at[base+i] != 2) ok = 0;
      chk("recal dir/width", ok, 1);
      t00_after = 0;
      @(negedge clk);
      // buffered 0 -> 3
      base = npulse;
      issue(0, 3, 1, 4, 10, 1000);
      wait_done(400, "buf");
      chk("buf pulses", npulse - base, 3);
      ok = 1;
      for (int i = 0; i < 3; i++) if (dir_at[base+i] !== 1'b1 || w_at[base+i] != 4) ok = 0;
      chk("buf dir/width", ok, 1);
      chk("buf space1", rise_at[base+1] - rise_at[base], 19);
      chk("buf space2", rise_at[base+2] - rise_at[base+1], 19);
      chk("buf cur", cur_cyl, 3);
      chk("buf err", err_code, 0);
      @(negedge clk);
      // normal 3 -> 1, engine must wait for seek_complete after each step
      seek_complete = 0;
      base = npulse;
      issue(0, 1, 0, 2, 1, 1000);
      repeat (10) @(negedge clk);
      cmd_cyl = 9; cmd_valid = 1;
      @(negedge clk);
      chk("busy ready", cmd_ready, 0);
      cmd_valid = 0;
      repeat (20) @(negedge clk);
      chk("norm wait settle", npulse - base, 1);
      seek_complete = 1;
      wait_done(200, "norm");
      chk("norm pulses", npulse - base, 2);
      ok = (dir_at[base] === 1'b0) && (dir_at[base+1] === 1'b0);
      chk("norm dir", ok, 1);
      chk("norm cur", cur_cyl, 1);
      chk("norm err", err_code, 0);
      @(negedge clk);
      chk("norm no extra cmd", busy, 0);
      // zero distance
      base = npulse;
      issue(0, 1, 0, 2, 1, 1000);
      @(negedge clk);
      chk("zero done", done, 1);
      chk("zero err", err_code, 0);
      chk("zero pulses", npulse - base, 0);
      @(negedge clk);
      // out of range
      base = npulse;
      issue(0, MAX_CYL + 1, 0, 2, 1, 1000);
      @(negedge clk);
      chk("range done", done, 1);
      chk("range err", err_code, 4);
      chk("range pulses", npulse - base, 0);
      chk("range cur", cur_cyl, 1);
      chk("range cal", cal_valid, 1);
      @(negedge clk);
      // highest legal cylinder
      base = npulse;
      issue(0, MAX_CYL, 1, 1, 1, 1000);
      wait_done(600, "max");
      chk("max pulses", npulse - base, MAX_CYL - 1);
      chk("max cur", cur_cyl, MAX_CYL);
      chk("max err", err_code, 0);
      @(negedge clk);
      // settle timeout
      seek_complete = 0;
      base = npulse;
      issue(0, MAX_CYL - 1, 0, 2, 1, 50);
      wait_done(300, "tmo");
      chk("tmo err", err_code, 1);
      chk("tmo cal", cal_valid, 0);
      chk("tmo cur", cur_cyl, MAX_CYL - 1);
      chk("tmo pulses", npulse - base, 1);
      seek_complete = 1;
      @(negedge clk);
      // recalibrate without track00
      base = npulse;
      issue(1, 0, 0, 1, 1, 1000);
      wait_done(600, "nt00");
      chk("nt00 pulses", npulse - base, RECAL_LIMIT);
      chk("nt00 err", err_code, 2);
      chk("nt00 cal", cal_valid, 0);
      @(negedge clk);
      // recalibrate already at track00
      base = npulse;
      recal_force();
      chk("r00 pulses", npulse - base, 0);
      chk("r00 err", err_code, 0);
      chk("r00 cal", cal_valid, 1);
      chk("r00 cur", cur_cyl, 0);
      @(negedge clk);
      // drive fault during a pulse
      issue(0, 5, 0, 8, 1, 1000);
      n = 0;
      while (step_pulse !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("flt pulse seen", step_pulse, 1);
      drive_fault = 1;
      @(negedge clk);
      drive_fault = 0;
      chk("flt pulse drop", step_pulse, 0);
      chk("flt done", done, 1);
      chk("flt err", err_code, 3);
      chk("flt cal", cal_valid, 0);
      chk("flt cur", cur_cyl, 0);
      @(negedge clk);
      // reset during GAP
      recal_force();
      @(negedge clk);
      issue(0, 3, 1, 2, 40, 1000);
      n = 0;
      while (step_pulse !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      while (step_pulse !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      repeat (4) @(negedge clk);
      chk("gap busy", busy, 1);
      chk("gap cur", cur_cyl, 1);
      base = npulse;
      reset = 1;
      @(negedge clk);
      chk("mrst step_pulse", step_pulse, 0);
      chk("mrst dir", step_direction, 0);
      chk("mrst cur", cur_cyl, 0);
      chk("mrst cal", cal_valid, 0);
      chk("mrst busy", busy, 0);
      chk("mrst done", done, 0);
      chk("mrst err", err_code, 0);
      chk("mrst ready", cmd_ready, 1);
      reset = 0;
      repeat (60) @(negedge clk);
      chk("mrst no pulse", npulse - base, 0);
      chk("mrst idle", busy, 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
